// File: rtl/v_state_table.sv
// rtl/v_state_table.sv - per-product state table, 1R1W with write-first bypass
// Clears every record after reset before serving reads and writes.
package cfg_pkg;
   localparam int ENTRIES_N = 16;
endpackage

package v_pkg;
   localparam int KEY_W = 8;
   localparam int VOL_W = 16;
   localparam int LS_W  = $clog2(cfg_pkg::ENTRIES_N + 1);

   typedef struct packed {
      logic [cfg_pkg::ENTRIES_N-1:0]            vld;
      logic [cfg_pkg::ENTRIES_N-1:0][KEY_W-1:0] key;
      logic [cfg_pkg::ENTRIES_N-1:0][VOL_W-1:0] volume;
      logic [LS_W-1:0]                          listsize;
   } state_t;
endpackage

module v_state_table #(
   parameter int PROD_N    = 256,
   parameter int ENTRIES_N = cfg_pkg::ENTRIES_N,
   parameter int ID_W      = $clog2(PROD_N),
   parameter int STATE_W   = $bits(v_pkg::state_t)
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               i_state_ren,
   input  logic [ID_W-1:0]    i_state_raddr,
   output logic [STATE_W-1:0] o_state_rdata,
   input  logic               i_state_wen,
   input  logic [ID_W-1:0]    i_state_waddr,
   input  logic [STATE_W-1:0] i_state_wdata,
   output logic               o_init_busy_r,
   output logic               o_wr_drop_r
);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} fsm_t;

   fsm_t               state;
   fsm_t               state_nxt;
   logic [ID_W-1:0]    init_addr;
   logic [STATE_W-1:0] mem [PROD_N];
   logic [STATE_W-1:0] ram_rdata;
   logic               mem_we;
   logic [ID_W-1:0]    mem_waddr;
   logic [STATE_W-1:0] mem_wdata;
   logic               sweep_last;
   logic               raddr_ok;
   logic               waddr_ok;
   logic               collide;

   if (ENTRIES_N != cfg_pkg::ENTRIES_N) begin : g_cfg_check
      $error("v_state_table: ENTRIES_N does not match the state_t record layout");
   end

   assign sweep_last = (init_addr == ID_W'(PROD_N - 1));
   assign raddr_ok   = (32'(i_state_raddr) < PROD_N);
   assign waddr_ok   = (32'(i_state_waddr) < PROD_N);
   assign collide    = i_state_wen && (i_state_waddr == i_state_raddr);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= INIT;
         init_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT && !sweep_last) begin
            init_addr <= init_addr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == INIT && sweep_last) begin
         state_nxt = READY;
      end
   end

   // The clear sweep owns the RAM write port until READY; user writes are dropped.
   always_comb begin
      mem_we    = i_state_wen && waddr_ok;
      mem_waddr = i_state_waddr;
      mem_wdata = i_state_wdata;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_addr;
         mem_wdata = '0;
      end
   end

   assign o_init_busy_r = (state == INIT);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign ram_rdata = mem[i_state_raddr];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_state_rdata <= '0;
         o_wr_drop_r   <= 1'b0;
      end else begin
         o_wr_drop_r <= (state == INIT) && i_state_wen;
         if (i_state_ren) begin
            if (state == INIT || !raddr_ok) begin
               o_state_rdata <= '0;
            end else if (collide) begin
               o_state_rdata <= i_state_wdata;
            end else begin
               o_state_rdata <= ram_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_v_state_table.sv
// tb/tb_v_state_table.sv - scoreboard bench for v_state_table
// Directed sweep/reset/bypass steps followed by a random read/write run.
module tb_v_state_table;
   import v_pkg::*;

   localparam int PROD_N  = 256;
   localparam int ID_W    = 8;
   localparam int STATE_W = $bits(state_t);

   logic               clk = 1'b0;
   logic               arst_n;
   logic               ren;
   logic [ID_W-1:0]    raddr;
   logic [STATE_W-1:0] rdata;
   logic               wen;
   logic [ID_W-1:0]    waddr;
   state_t             wdata;
   logic               busy;
   logic               drop;

   state_t model [PROD_N];
   state_t exp_q [$];
   state_t last_rd;
   int     errors = 0;
   int     checks = 0;

   always #5 clk = ~clk;

   v_state_table #(.PROD_N(PROD_N)) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .i_state_ren   (ren),
      .i_state_raddr (raddr),
      .o_state_rdata (rdata),
      .i_state_wen   (wen),
      .i_state_waddr (waddr),
      .i_state_wdata (wdata),
      .o_init_busy_r (busy),
      .o_wr_drop_r   (drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic state_t rand_state();
      logic [STATE_W-1:0] v;
      for (int i = 0; i < STATE_W; i++) v[i] = 1'($urandom);
      return state_t'(v);
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [STATE_W-1:0] obs,
                            input logic [STATE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; init_m tells the model the table is still sweeping.
   task automatic cyc(input logic r, input logic [ID_W-1:0] ra, input logic w,
                      input logic [ID_W-1:0] wa, input state_t wd, input logic init_m);
      logic exp_drop;
      ren   = r;
      raddr = ra;
      wen   = w;
      waddr = wa;
      wdata = wd;
      if (r) exp_q.push_back(init_m ? state_t'('0) : ((w && wa == ra) ? wd : model[ra]));
      exp_drop = w & init_m;
      tick();
      if (w && !init_m) model[wa] = wd;
      ren = 1'b0;
      wen = 1'b0;
      chk_bit("wr_drop", drop, exp_drop);
      if (exp_q.size() > 0) last_rd = exp_q.pop_front();
      chk_state(r ? "rdata" : "rdata_hold", rdata, last_rd);
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      ren    = 1'b0;
      wen    = 1'b0;
      #1;
      chk_bit("reset_busy", busy, 1'b1);
      chk_bit("reset_drop", drop, 1'b0);
      chk_state("reset_rdata", rdata, '0);
      tick();
      arst_n = 1'b1;
      exp_q.delete();
      last_rd = '0;
   endtask

   // Busy must read 1 before each of exactly PROD_N edges and 0 afterwards.
   task automatic sweep_check(input int wr_at, input int rd_at, input int start);
      for (int i = start; i < PROD_N; i++) begin
         chk_bit("sweep_busy", busy, 1'b1);
         cyc(rd_at == i, 8'd17, wr_at == i, 8'd3, rand_state(), 1'b1);
      end
      chk_bit("sweep_done", busy, 1'b0);
      for (int a = 0; a < PROD_N; a++) model[a] = '0;
   endtask

   initial begin
      state_t s;
      state_t r1;
      state_t r2;
      arst_n  = 1'b1;
      ren     = 1'b0;
      wen     = 1'b0;
      raddr   = '0;
      waddr   = '0;
      wdata   = '0;
      last_rd = '0;

      // Reset state and full post-reset sweep, then cleared records.
      do_reset();
      sweep_check(-1, -1, 0);
      cyc(1'b1, 8'd0,   1'b0, 8'd0, '0, 1'b0);
      cyc(1'b1, 8'd17,  1'b0, 8'd0, '0, 1'b0);
      cyc(1'b1, 8'd255, 1'b0, 8'd0, '0, 1'b0);

      // Write a record, read it back the following cycle.
      s          = '0;
      s.vld      = 16'h0004;
      s.key[2]   = 8'h3A;
      s.listsize = 5'd1;
      cyc(1'b0, 8'd0, 1'b1, 8'd5, s, 1'b0);
      cyc(1'b1, 8'd5, 1'b0, 8'd0, '0, 1'b0);

      // Same-address bypass, then different-address read of old data.
      r1 = rand_state();
      r2 = rand_state();
      cyc(1'b1, 8'd9,  1'b1, 8'd9,  r1, 1'b0);
      cyc(1'b1, 8'd9,  1'b1, 8'd10, r2, 1'b0);
      cyc(1'b1, 8'd10, 1'b0, 8'd0,  '0, 1'b0);
      cyc(1'b0, 8'd0,  1'b0, 8'd0,  '0, 1'b0);

      // Back-to-back writes to one address: last writer wins.
      cyc(1'b0, 8'd0, 1'b1, 8'd7, rand_state(), 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 8'd7, rand_state(), 1'b0);
      cyc(1'b1, 8'd7, 1'b0, 8'd0, '0, 1'b0);

      // Write during the sweep is dropped; read during the sweep returns zero.
      do_reset();
      sweep_check(10, 20, 0);
      cyc(1'b1, 8'd3, 1'b0, 8'd0, '0, 1'b0);

      // Reset at sweep cycle 100 while a drop pulse is showing.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         chk_bit("sweep_busy", busy, 1'b1);
         cyc(1'b0, 8'd0, i == 99, 8'd3, rand_state(), 1'b1);
      end
      do_reset();
      sweep_check(-1, -1, 0);

      // Random traffic against the model, biased toward a few hot IDs.
      for (int n = 0; n < 10000; n++) begin
         logic            r;
         logic            w;
         logic [ID_W-1:0] ra;
         logic [ID_W-1:0] wa;
         r  = 1'($urandom);
         w  = 1'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         cyc(r, ra, w, wa, rand_state(), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
